// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps the scheduler's {last,byte} stream with preamble/SFD,
// appends the CRC-32 FCS, enforces the inter-frame gap and counts sent/dropped frames.
module gmii_tx_framer #(
    parameter int IFG_CYCLES = 12,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [8:0]       iv_data,
    input  logic             i_data_wr,
    output logic [7:0]       ov_gmii_txd,
    output logic             o_gmii_tx_en,
    output logic             o_gmii_tx_er,
    output logic             o_frame_done,
    output logic [CNT_W-1:0] ov_frame_cnt,
    output logic [CNT_W-1:0] ov_drop_cnt,
    output logic             o_underrun_err
);

    localparam int DL_DEPTH = 8;
    localparam int PH_W     = $clog2((IFG_CYCLES > 8) ? IFG_CYCLES : 8);
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, FCS, IFG} state_t;

    typedef struct packed {
        logic       vld;
        logic       last;
        logic [7:0] dat;
    } dl_t;

    state_t                  state;
    logic [PH_W-1:0]         phase_cnt;
    logic [31:0]             crc;
    logic [31:0]             fcs;
    dl_t                     in_q;
    dl_t [DL_DEPTH-1:0]      dl;
    dl_t                     head;
    logic                    in_open;
    logic                    drop;
    logic                    accept;
    logic                    hole;
    logic                    rej;
    logic                    flush;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    assign head  = dl[DL_DEPTH-1];
    assign fcs   = ~crc;
    // in_open tracks an input frame still streaming in; only its bytes may join the line
    assign accept = i_data_wr & (((state == IDLE) & ~drop) |
                                 (((state == PREAMBLE) | (state == DATA)) & in_open));
    assign hole  = in_open & ~i_data_wr;
    assign rej   = i_data_wr & ~accept & ~drop;
    assign flush = (state == DATA) & ~head.vld;

    // Input capture stage plus delay line: aligns frame byte 0 with the end of the preamble
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_q <= '0;
            dl   <= '0;
        end else if (flush) begin
            in_q <= '0;
            dl   <= '0;
        end else begin
            in_q <= '{vld: accept, last: iv_data[8], dat: iv_data[7:0]};
            dl   <= {dl[DL_DEPTH-2:0], in_q};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_open     <= 1'b0;
            drop        <= 1'b0;
            ov_drop_cnt <= '0;
        end else begin
            if (accept)
                in_open <= ~iv_data[8];
            else if (hole)
                in_open <= 1'b0;

            // An aborted frame's tail is discarded silently; only foreign frames are counted
            if (i_data_wr & drop & iv_data[8])
                drop <= 1'b0;
            else if ((rej & ~iv_data[8]) | hole)
                drop <= 1'b1;

            if (rej)
                ov_drop_cnt <= ov_drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            phase_cnt      <= '0;
            crc            <= CRC_INIT;
            ov_gmii_txd    <= 8'h00;
            o_gmii_tx_en   <= 1'b0;
            o_gmii_tx_er   <= 1'b0;
            o_frame_done   <= 1'b0;
            o_underrun_err <= 1'b0;
            ov_frame_cnt   <= '0;
        end else begin
            o_gmii_tx_er   <= 1'b0;
            o_frame_done   <= 1'b0;
            o_underrun_err <= 1'b0;
            case (state)
                IDLE: begin
                    ov_gmii_txd  <= 8'h00;
                    o_gmii_tx_en <= 1'b0;
                    if (accept) begin
                        state     <= PREAMBLE;
                        phase_cnt <= '0;
                    end
                end
                PREAMBLE: begin
                    o_gmii_tx_en <= 1'b1;
                    ov_gmii_txd  <= (phase_cnt == PH_W'(7)) ? 8'hD5 : 8'h55;
                    if (phase_cnt == PH_W'(7)) begin
                        state     <= DATA;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                DATA: begin
                    o_gmii_tx_en <= 1'b1;
                    if (!head.vld) begin
                        ov_gmii_txd    <= 8'h00;
                        o_gmii_tx_er   <= 1'b1;
                        o_underrun_err <= 1'b1;
                        crc            <= CRC_INIT;
                        state          <= IFG;
                        phase_cnt      <= '0;
                    end else begin
                        ov_gmii_txd <= head.dat;
                        crc         <= crc_byte(crc, head.dat);
                        if (head.last) begin
                            state     <= FCS;
                            phase_cnt <= '0;
                        end
                    end
                end
                FCS: begin
                    o_gmii_tx_en <= 1'b1;
                    ov_gmii_txd  <= fcs[{phase_cnt[1:0], 3'b000} +: 8];
                    if (phase_cnt == PH_W'(3)) begin
                        o_frame_done <= 1'b1;
                        ov_frame_cnt <= ov_frame_cnt + 1'b1;
                        crc          <= CRC_INIT;
                        state        <= IFG;
                        phase_cnt    <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                IFG: begin
                    ov_gmii_txd  <= 8'h00;
                    o_gmii_tx_en <= 1'b0;
                    if (phase_cnt == PH_W'(IFG_CYCLES - 1)) begin
                        state     <= IDLE;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    phase_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: per-cycle GMII trace compared against a frame-level model.
module tb_gmii_tx_framer;

    localparam int CNT_W = 16;
    localparam int IFG   = 12;
    localparam int MAXC  = 2048;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic [8:0]       iv_data = 9'h0;
    logic             i_data_wr = 1'b0;
    logic [7:0]       ov_gmii_txd;
    logic             o_gmii_tx_en;
    logic             o_gmii_tx_er;
    logic             o_frame_done;
    logic [CNT_W-1:0] ov_frame_cnt;
    logic [CNT_W-1:0] ov_drop_cnt;
    logic             o_underrun_err;

    always #4 i_clk = ~i_clk;

    gmii_tx_framer #(.IFG_CYCLES(IFG), .CNT_W(CNT_W)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .iv_data        (iv_data),
        .i_data_wr      (i_data_wr),
        .ov_gmii_txd    (ov_gmii_txd),
        .o_gmii_tx_en   (o_gmii_tx_en),
        .o_gmii_tx_er   (o_gmii_tx_er),
        .o_frame_done   (o_frame_done),
        .ov_frame_cnt   (ov_frame_cnt),
        .ov_drop_cnt    (ov_drop_cnt),
        .o_underrun_err (o_underrun_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // trace word: [43]en [42]er [41:34]txd [33]done [32]underrun [31:16]frame_cnt [15:0]drop_cnt
    logic        s_wr  [MAXC];
    logic [8:0]  s_dat [MAXC];
    logic [43:0] obs_v [MAXC];
    logic [43:0] exp_v [MAXC];
    logic        e_en [MAXC], e_er [MAXC], e_done [MAXC], e_und [MAXC], ev_drop [MAXC];
    logic [7:0]  e_txd [MAXC];
    logic [7:0]  kv [21];
    int          slen;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        repeat (8) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            s_wr[i]  = 1'b0;
            s_dat[i] = 9'h0;
        end
    endtask

    task automatic add_frame(input int start, input int n, input int hole, output int nxt);
        int p;
        p = start;
        for (int k = 0; k < n; k++) begin
            if (hole > 0 && k == hole) p++;
            s_wr[p]  = 1'b1;
            s_dat[p] = {(k == n - 1), 8'($urandom)};
            p++;
        end
        nxt = p;
    endtask

    task automatic add_known(input int start);
        for (int k = 0; k < 9; k++) begin
            s_wr[start+k]  = 1'b1;
            s_dat[start+k] = {(k == 8), 8'h31 + 8'(k)};
        end
    endtask

    // Frame-level reference: each accepted frame owns the line until its IFG expires
    task automatic build_model(input int len);
        int c, free_at, t0, k;
        bit dropping, hole;
        logic [31:0] crc;
        logic [15:0] fc, dc;
        for (int i = 0; i < MAXC; i++) begin
            e_en[i] = 0; e_er[i] = 0; e_done[i] = 0; e_und[i] = 0; ev_drop[i] = 0; e_txd[i] = 0;
        end
        free_at = 0; dropping = 0; c = 0;
        while (c < len) begin
            if (!s_wr[c]) c++;
            else if (dropping) begin
                if (s_dat[c][8]) dropping = 0;
                c++;
            end else if (c < free_at) begin
                ev_drop[c] = 1;
                if (!s_dat[c][8]) dropping = 1;
                c++;
            end else begin
                t0 = c; crc = 32'hFFFFFFFF; k = 0; hole = 0;
                for (int i = 0; i < 8; i++) begin
                    e_en[t0+1+i]  = 1;
                    e_txd[t0+1+i] = (i == 7) ? 8'hD5 : 8'h55;
                end
                while (t0 + k < len) begin
                    if (!s_wr[t0+k]) begin hole = 1; break; end
                    crc = crc_upd(crc, s_dat[t0+k][7:0]);
                    e_en[t0+9+k]  = 1;
                    e_txd[t0+9+k] = s_dat[t0+k][7:0];
                    if (s_dat[t0+k][8]) break;
                    k++;
                end
                if (hole) begin
                    e_en[t0+9+k] = 1; e_er[t0+9+k] = 1; e_und[t0+9+k] = 1;
                    free_at = t0 + k + 22;
                    dropping = 1;
                end else begin
                    for (int j = 0; j < 4; j++) begin
                        e_en[t0+10+k+j]  = 1;
                        e_txd[t0+10+k+j] = 8'((~crc) >> (8 * j));
                    end
                    e_done[t0+13+k] = 1;
                    free_at = t0 + k + 26;
                end
                c = t0 + k + 1;
            end
        end
        fc = 0; dc = 0;
        for (int i = 0; i < len; i++) begin
            if (e_done[i]) fc++;
            if (ev_drop[i]) dc++;
            exp_v[i] = {e_en[i], e_er[i], e_txd[i], e_done[i], e_und[i], fc, dc};
        end
    endtask

    task automatic run_stim(input int len, input bit do_reset);
        if (do_reset) begin
            i_rst_n = 1'b0; i_data_wr = 1'b0; iv_data = 9'h0;
            repeat (3) @(negedge i_clk);
        end
        i_rst_n = 1'b1;
        for (int c = 0; c < len; c++) begin
            i_data_wr = s_wr[c];
            iv_data   = s_dat[c];
            @(negedge i_clk);
            obs_v[c] = {o_gmii_tx_en, o_gmii_tx_er, ov_gmii_txd, o_frame_done,
                        o_underrun_err, ov_frame_cnt, ov_drop_cnt};
        end
        i_data_wr = 1'b0;
    endtask

    task automatic test_reset();
        logic [43:0] o;
        i_rst_n = 1'b0;
        for (int c = 0; c < 12; c++) begin
            i_data_wr = ~i_data_wr;
            iv_data   = 9'($urandom);
            @(negedge i_clk);
            o = {o_gmii_tx_en, o_gmii_tx_er, ov_gmii_txd, o_frame_done,
                 o_underrun_err, ov_frame_cnt, ov_drop_cnt};
            n_vec++;
            if (o !== 44'h0) begin
                n_err++;
                $display("FAIL reset cycle %0d: got %h want 0", c, o);
            end
        end
        i_data_wr = 1'b0;
    endtask

    task automatic test_known_vector();
        int en_cnt;
        kv = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
               8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
        clear_stim(); add_known(2); slen = 60;
        build_model(slen); run_stim(slen, 1);
        for (int c = 0; c < slen; c++) begin
            n_vec++;
            if (obs_v[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL known_trace cycle %0d: got %h want %h", c, obs_v[c], exp_v[c]);
            end
        end
        en_cnt = 0;
        for (int c = 0; c < slen; c++) if (obs_v[c][43]) en_cnt++;
        for (int i = 0; i < 21; i++) begin
            n_vec++;
            if (obs_v[3+i][41:34] !== kv[i] || obs_v[3+i][43] !== 1'b1) begin
                n_err++;
                $display("FAIL known_txd idx %0d: got %h want %h", i, obs_v[3+i][41:34], kv[i]);
            end
        end
        n_vec++;
        if (en_cnt != 21 || obs_v[23][33] !== 1'b1 || obs_v[slen-1][31:16] !== 16'd1) begin
            n_err++;
            $display("FAIL known_summary: en=%0d done=%b cnt=%0d want 21 1 1",
                     en_cnt, obs_v[23][33], obs_v[slen-1][31:16]);
        end
    endtask

    task automatic test_spaced();
        int nxt, gap, c;
        clear_stim();
        add_frame(2, 60, 0, nxt);          // last byte at 61
        add_frame(61 + 36, 60, 0, nxt);    // 23 idle GMII cycles between the frames
        slen = nxt + 40;
        build_model(slen); run_stim(slen, 1);
        for (int i = 0; i < slen; i++) begin
            n_vec++;
            if (obs_v[i] !== exp_v[i]) begin
                n_err++;
                $display("FAIL spaced_trace cycle %0d: got %h want %h", i, obs_v[i], exp_v[i]);
            end
        end
        c = 0;
        while (c < slen && !obs_v[c][33]) c++;
        gap = 0; c++;
        while (c < slen && !obs_v[c][43]) begin gap++; c++; end
        n_vec++;
        if (gap < IFG || obs_v[slen-1][31:16] !== 16'd2 || obs_v[slen-1][15:0] !== 16'd0) begin
            n_err++;
            $display("FAIL spaced_summary: gap=%0d frames=%0d drops=%0d want >=12 2 0",
                     gap, obs_v[slen-1][31:16], obs_v[slen-1][15:0]);
        end
    endtask

    task automatic test_drop();
        int nxt, en_cnt;
        clear_stim();
        add_frame(2, 60, 0, nxt);          // last byte at 61
        add_frame(66, 10, 0, nxt);         // 5 cycles after that last byte
        add_frame(106, 60, 0, nxt);
        slen = nxt + 40;
        build_model(slen); run_stim(slen, 1);
        for (int i = 0; i < slen; i++) begin
            n_vec++;
            if (obs_v[i] !== exp_v[i]) begin
                n_err++;
                $display("FAIL drop_trace cycle %0d: got %h want %h", i, obs_v[i], exp_v[i]);
            end
        end
        en_cnt = 0;
        for (int i = 0; i < slen; i++) if (obs_v[i][43]) en_cnt++;
        n_vec++;
        if (en_cnt != 144 || obs_v[slen-1][15:0] !== 16'd1 || obs_v[slen-1][31:16] !== 16'd2) begin
            n_err++;
            $display("FAIL drop_summary: en=%0d drops=%0d frames=%0d want 144 1 2",
                     en_cnt, obs_v[slen-1][15:0], obs_v[slen-1][31:16]);
        end
    endtask

    task automatic test_underrun();
        int nxt, er_cnt;
        clear_stim();
        add_frame(2, 20, 10, nxt);         // hole at input cycle 12
        add_frame(60, 60, 0, nxt);
        slen = nxt + 40;
        build_model(slen); run_stim(slen, 1);
        for (int i = 0; i < slen; i++) begin
            n_vec++;
            if (obs_v[i] !== exp_v[i]) begin
                n_err++;
                $display("FAIL underrun_trace cycle %0d: got %h want %h", i, obs_v[i], exp_v[i]);
            end
        end
        er_cnt = 0;
        for (int i = 0; i < slen; i++) if (obs_v[i][42]) er_cnt++;
        n_vec++;
        if (er_cnt != 1 || obs_v[21][42] !== 1'b1 || obs_v[21][32] !== 1'b1 ||
            obs_v[40][31:16] !== 16'd0 || obs_v[slen-1][31:16] !== 16'd1) begin
            n_err++;
            $display("FAIL underrun_summary: er=%0d er@21=%b und@21=%b cnt40=%0d cntend=%0d want 1 1 1 0 1",
                     er_cnt, obs_v[21][42], obs_v[21][32], obs_v[40][31:16], obs_v[slen-1][31:16]);
        end
    endtask

    task automatic test_reset_mid_fcs();
        clear_stim(); add_known(2); slen = 60;
        i_rst_n = 1'b0; i_data_wr = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int c = 0; c <= 21; c++) begin
            i_data_wr = s_wr[c];
            iv_data   = s_dat[c];
            if (c < 21) @(negedge i_clk);
            else @(posedge i_clk);
        end
        #1;
        n_vec++;
        if (o_gmii_tx_en !== 1'b1 || ov_gmii_txd !== 8'h39) begin
            n_err++;
            $display("FAIL midfcs_before: en=%b txd=%h want 1 39", o_gmii_tx_en, ov_gmii_txd);
        end
        #1 i_rst_n = 1'b0;
        #1;
        n_vec++;
        if (o_gmii_tx_en !== 1'b0 || ov_gmii_txd !== 8'h00 || ov_frame_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL midfcs_async: en=%b txd=%h cnt=%0d want 0 00 0",
                     o_gmii_tx_en, ov_gmii_txd, ov_frame_cnt);
        end
        i_data_wr = 1'b0;
        @(negedge i_clk);
        build_model(slen); run_stim(slen, 0);
        for (int i = 0; i < slen; i++) begin
            n_vec++;
            if (obs_v[i] !== exp_v[i]) begin
                n_err++;
                $display("FAIL midfcs_trace cycle %0d: got %h want %h", i, obs_v[i], exp_v[i]);
            end
        end
        n_vec++;
        if (obs_v[23][41:34] !== 8'hCB || obs_v[20][41:34] !== 8'h26) begin
            n_err++;
            $display("FAIL midfcs_fcs: first=%h last=%h want 26 CB", obs_v[20][41:34], obs_v[23][41:34]);
        end
    endtask

    task automatic test_random();
        int pos, nxt, n, hole;
        for (int r = 0; r < 3; r++) begin
            clear_stim();
            pos = 2;
            for (int f = 0; f < 8; f++) begin
                n = ($urandom % 4 == 0) ? $urandom_range(12, 1) : $urandom_range(75, 60);
                hole = (n >= 2 && $urandom % 5 == 0) ? $urandom_range(n - 1, 1) : 0;
                add_frame(pos, n, hole, nxt);
                pos = nxt + $urandom_range(45, 0);
            end
            slen = pos + 40;
            build_model(slen); run_stim(slen, 1);
            for (int i = 0; i < slen; i++) begin
                n_vec++;
                if (obs_v[i] !== exp_v[i]) begin
                    n_err++;
                    $display("FAIL random%0d cycle %0d: got %h want %h", r, i, obs_v[i], exp_v[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_spaced();
        test_drop();
        test_underrun();
        test_reset_mid_fcs();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
